// File: rtl/nios2_qsys_div_cell_if.sv
// Request/result bundle between the A-stage and the iterative divide cell.
interface nios2_qsys_div_cell_if #(
   parameter int WIDTH = 32
);
   logic             A_div_start;
   logic             A_div_signed;
   logic [WIDTH-1:0] A_div_src1;
   logic [WIDTH-1:0] A_div_src2;
   logic             A_div_busy;
   logic             A_div_done;
   logic [WIDTH-1:0] A_div_quot;
   logic [WIDTH-1:0] A_div_rem;

   modport master (
      output A_div_start, A_div_signed, A_div_src1, A_div_src2,
      input  A_div_busy, A_div_done, A_div_quot, A_div_rem
   );

   modport slave (
      input  A_div_start, A_div_signed, A_div_src1, A_div_src2,
      output A_div_busy, A_div_done, A_div_quot, A_div_rem
   );
endinterface

// File: rtl/nios2_qsys_div_cell.sv
// Radix-2 restoring divider with a fixed latency, truncating signed semantics.
// Operates on magnitudes and applies the result signs in a single fix-up cycle.
module nios2_qsys_div_cell #(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   nios2_qsys_div_cell_if.slave  div
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

   state_t           state, next_state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] prem, dvd, dvs, res_q, res_r;
   logic             q_neg, r_neg, dz, sgn, wr_pend;
   logic             s1, s2;
   logic [WIDTH:0]   trial;

   assign s1    = div.A_div_signed & div.A_div_src1[WIDTH-1];
   assign s2    = div.A_div_signed & div.A_div_src2[WIDTH-1];
   // Bit WIDTH of the trial difference is the borrow: set means "does not fit".
   assign trial = {prem, dvd[WIDTH-1]} - {1'b0, dvs};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      // NOTE: default first so every path assigns next_state and no latch is inferred.
      next_state = state;
      unique case (state)
         IDLE:    if (div.A_div_start) next_state = CALC;
         CALC:    if (cnt == LAST)     next_state = FIXUP;
         FIXUP:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: datapath registers are reset too, so outputs read 0 right after reset_n drops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt            <= '0;
         prem           <= '0;
         dvd            <= '0;
         dvs            <= '0;
         res_q          <= '0;
         res_r          <= '0;
         q_neg          <= 1'b0;
         r_neg          <= 1'b0;
         dz             <= 1'b0;
         sgn            <= 1'b0;
         wr_pend        <= 1'b0;
         div.A_div_busy <= 1'b0;
         div.A_div_done <= 1'b0;
         div.A_div_quot <= '0;
         div.A_div_rem  <= '0;
      end else begin
         // NOTE: non-blocking throughout so every register sees pre-edge values.
         wr_pend        <= 1'b0;
         div.A_div_done <= wr_pend;
         div.A_div_busy <= (state != IDLE);
         if (wr_pend) begin
            div.A_div_quot <= res_q;
            div.A_div_rem  <= res_r;
         end
         unique case (state)
            IDLE: begin
               if (div.A_div_start) begin
                  dvd   <= s1 ? -div.A_div_src1 : div.A_div_src1;
                  dvs   <= s2 ? -div.A_div_src2 : div.A_div_src2;
                  q_neg <= s1 ^ s2;
                  r_neg <= s1;
                  sgn   <= div.A_div_signed;
                  dz    <= (div.A_div_src2 == '0);
                  prem  <= '0;
                  cnt   <= '0;
               end
            end
            CALC: begin
               prem <= trial[WIDTH] ? {prem[WIDTH-2:0], dvd[WIDTH-1]} : trial[WIDTH-1:0];
               dvd  <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
               cnt  <= cnt + 1'b1;
            end
            FIXUP: begin
               // A zero divisor leaves all-ones quotient bits; the sign flip must not touch it.
               res_q   <= dz ? '1 : ((sgn & q_neg) ? -dvd : dvd);
               res_r   <= (sgn & r_neg) ? -prem : prem;
               wr_pend <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nios2_qsys_div_cell.sv
// Directed bench for nios2_qsys_div_cell: vector table plus handshake/reset sequences.
module tb_nios2_qsys_div_cell;

   localparam int W = 32;

   typedef struct {
      string       name;
      logic        sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] eq;
      logic [W-1:0] er;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [W-1:0] prev_q = '0;
   logic [W-1:0] prev_r = '0;
   vec_t vecs[12];

   nios2_qsys_div_cell_if #(.WIDTH(W)) d ();

   nios2_qsys_div_cell #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .div     (d)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Call at a negedge; drives start immediately and returns at the negedge of the done cycle.
   task automatic run_op(input vec_t v, input int extra_k, input logic [W-1:0] xa,
                         input logic [W-1:0] xb);
      int   done_k;
      logic busy_ok;
      logic hold_ok;
      done_k  = -1;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      d.A_div_start  = 1'b1;
      d.A_div_signed = v.sgn;
      d.A_div_src1   = v.a;
      d.A_div_src2   = v.b;
      @(posedge clk);
      @(negedge clk);
      d.A_div_start = 1'b0;
      if (d.A_div_busy !== 1'b0 || d.A_div_done !== 1'b0) busy_ok = 1'b0;
      for (int k = 1; k <= W + 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         d.A_div_start = 1'b0;
         if (d.A_div_done === 1'b1) begin
            done_k = k;
            if (d.A_div_busy !== 1'b0) busy_ok = 1'b0;
            break;
         end
         if (d.A_div_busy !== (k <= W + 1)) busy_ok = 1'b0;
         if (d.A_div_quot !== prev_q || d.A_div_rem !== prev_r) hold_ok = 1'b0;
         if (k == extra_k) begin
            d.A_div_start = 1'b1;
            d.A_div_src1  = xa;
            d.A_div_src2  = xb;
         end
      end
      check($sformatf("%s latency", v.name), W'(done_k), W'(W + 2));
      check($sformatf("%s quot", v.name), d.A_div_quot, v.eq);
      check($sformatf("%s rem", v.name), d.A_div_rem, v.er);
      check($sformatf("%s busy window", v.name), W'(busy_ok), W'(1));
      check($sformatf("%s result hold", v.name), W'(hold_ok), W'(1));
      prev_q = v.eq;
      prev_r = v.er;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen_done;
      vec_t v;

      vecs[0]  = '{"u100/7",      1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
      vecs[1]  = '{"s-7/2",       1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
      vecs[2]  = '{"u1234/0",     1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234};
      vecs[3]  = '{"s-5/0",       1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
      vecs[4]  = '{"s_min/-1",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
      vecs[5]  = '{"u_max/1",     1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
      vecs[6]  = '{"u5/9",        1'b0, 32'd5,          32'd9,          32'd0,          32'd5};
      vecs[7]  = '{"s7/-2",       1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
      vecs[8]  = '{"s-100/-7",    1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
      vecs[9]  = '{"u_max/16",    1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF};
      vecs[10] = '{"s_min/2",     1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0};
      vecs[11] = '{"u_max/0_sgn", 1'b1, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  32'h8000_0000};

      d.A_div_start  = 1'b0;
      d.A_div_signed = 1'b0;
      d.A_div_src1   = '0;
      d.A_div_src2   = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset busy", W'(d.A_div_busy), W'(0));
      check("reset done", W'(d.A_div_done), W'(0));
      check("reset quot", d.A_div_quot, '0);
      check("reset rem", d.A_div_rem, '0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Back-to-back: each new start lands in the previous done cycle.
      for (int i = 0; i < 12; i++) run_op(vecs[i], 0, '0, '0);

      // Second start 8/2 at E+5 must be ignored.
      v = '{"ignored_start", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0};
      run_op(v, 4, 32'd8, 32'd2);
      v = '{"after_ignored", 1'b0, 32'd8, 32'd2, 32'd4, 32'd0};
      run_op(v, 0, '0, '0);

      // Abort mid-operation with reset.
      d.A_div_start  = 1'b1;
      d.A_div_signed = 1'b0;
      d.A_div_src1   = 32'd1000;
      d.A_div_src2   = 32'd3;
      @(posedge clk);
      @(negedge clk);
      d.A_div_start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("midreset busy", W'(d.A_div_busy), W'(0));
      check("midreset done", W'(d.A_div_done), W'(0));
      check("midreset quot", d.A_div_quot, '0);
      check("midreset rem", d.A_div_rem, '0);
      @(negedge clk);
      reset_n = 1'b1;
      seen_done = 1'b0;
      repeat (W + 8) begin
         @(negedge clk);
         if (d.A_div_done === 1'b1) seen_done = 1'b1;
      end
      check("midreset no done", W'(seen_done), W'(0));
      prev_q = '0;
      prev_r = '0;
      v = '{"after_reset", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0};
      run_op(v, 0, '0, '0);

      @(negedge clk);
      check("done one-cycle", W'(d.A_div_done), W'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
